// File: rtl/test_pattern_pkg.sv
// Shared definitions for the SVGA test-screen path: one-hot screen codes,
// the screen rotation order and the default auto-advance period.
package test_pattern_pkg;

    localparam logic [3:0] IMAGE_STATE_RECTANGLE  = 4'b0001;
    localparam logic [3:0] IMAGE_STATE_V_BARS     = 4'b0010;
    localparam logic [3:0] IMAGE_STATE_H_BARS     = 4'b0100;
    localparam logic [3:0] IMAGE_STATE_GRAY_SCALE = 4'b1000;

    localparam int DEFAULT_FRAMES_PER_IMAGE = 150;

    typedef enum logic [3:0] {
        RECTANGLE  = IMAGE_STATE_RECTANGLE,
        V_BARS     = IMAGE_STATE_V_BARS,
        H_BARS     = IMAGE_STATE_H_BARS,
        GRAY_SCALE = IMAGE_STATE_GRAY_SCALE
    } image_state_t;

    // Screen rotation; anything unexpected falls back to the first screen.
    function automatic image_state_t next_image_state(input image_state_t cur);
        case (cur)
            RECTANGLE:  return V_BARS;
            V_BARS:     return H_BARS;
            H_BARS:     return GRAY_SCALE;
            GRAY_SCALE: return RECTANGLE;
            default:    return RECTANGLE;
        endcase
    endfunction

    function automatic logic is_one_hot(input logic [3:0] value);
        return (value != 4'd0) && ((value & (value - 4'd1)) == 4'd0);
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchronizer plus stable-level debouncer for one active-low board
// button. The debounced level only follows the synchronized input after it
// has differed for DEBOUNCE_CYCLES consecutive cycles.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 400000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic button_n,
    output logic level
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_a;
    logic          sync_b;
    logic [CW-1:0] count;

    // Bring the asynchronous button into the clock domain; released = 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_a <= 1'b1;
            sync_b <= 1'b1;
        end else begin
            sync_a <= button_n;
            sync_b <= sync_a;
        end
    end

    // Accept a new level only after it has been stable for the full window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level <= 1'b1;
            count <= '0;
        end else if (sync_b == level) begin
            count <= '0;
        end else if (count == LAST) begin
            level <= sync_b;
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/test_pattern_sequencer.sv
// Frame-synchronous test-screen selector. Auto-advances every
// FRAMES_PER_IMAGE frames; screen changes happen only on a VS rising edge.
// Define MANUAL_CONTROL_EN to enable the Next/Pause board buttons; without
// it the button ports are ignored and Paused stays low.
module test_pattern_sequencer
    import test_pattern_pkg::*;
#(
    parameter int   FRAMES_PER_IMAGE = DEFAULT_FRAMES_PER_IMAGE,
    parameter int   DEBOUNCE_CYCLES  = 400000,
    parameter logic SYNC_H           = 1'b1
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       VS,
    input  logic       NextButtonN,
    input  logic       PauseButtonN,
    output logic [3:0] ImageState,
    output logic       FrameStrobe,
    output logic       Paused
);

    localparam logic       SYNC_L = ~SYNC_H;
    localparam logic [7:0] RELOAD = 8'(FRAMES_PER_IMAGE);

    logic         vs_d;
    logic         frame_start;
    image_state_t state;
    image_state_t state_next;
    logic [7:0]   count;
    logic [7:0]   count_next;
    logic         next_pending;
    logic         paused;

    // Delayed VS for edge detection; resets to the asserted level so the
    // first cycle after reset release cannot look like a frame start.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            vs_d <= SYNC_H;
        end else begin
            vs_d <= VS;
        end
    end

    assign frame_start = (VS == SYNC_H) && (vs_d == SYNC_L);

`ifdef MANUAL_CONTROL_EN
    logic next_level;
    logic pause_level;
    logic next_level_d;
    logic pause_level_d;
    logic next_press;
    logic pause_press;

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next_debouncer (
        .clk      (Clock),
        .rst_n    (Reset),
        .button_n (NextButtonN),
        .level    (next_level)
    );

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_pause_debouncer (
        .clk      (Clock),
        .rst_n    (Reset),
        .button_n (PauseButtonN),
        .level    (pause_level)
    );

    // Remember the previous debounced levels to find press (1 -> 0) edges.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            next_level_d  <= 1'b1;
            pause_level_d <= 1'b1;
        end else begin
            next_level_d  <= next_level;
            pause_level_d <= pause_level;
        end
    end

    assign next_press  = next_level_d & ~next_level;
    assign pause_press = pause_level_d & ~pause_level;

    // A press on the frame_start cycle wins, so it is served one frame later.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            next_pending <= 1'b0;
            paused       <= 1'b0;
        end else begin
            if (next_press) begin
                next_pending <= 1'b1;
            end else if (frame_start) begin
                next_pending <= 1'b0;
            end
            if (pause_press) begin
                paused <= ~paused;
            end
        end
    end
`else
    logic unused_buttons;
    localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;

    assign unused_buttons = NextButtonN ^ PauseButtonN;
    assign next_pending   = 1'b0;
    assign paused         = 1'b0;
`endif

    // Screen and frame-counter next state, evaluated only at frame starts.
    always_comb begin
        state_next = state;
        count_next = count;
        if (frame_start) begin
            if (!is_one_hot(state)) begin
                state_next = RECTANGLE;
                count_next = RELOAD;
            end else if (next_pending) begin
                state_next = next_image_state(state);
                count_next = RELOAD;
            end else if (!paused) begin
                if (count == 8'd1) begin
                    state_next = next_image_state(state);
                    count_next = RELOAD;
                end else begin
                    count_next = count - 8'd1;
                end
            end
        end
    end

    // Screen, counter and the one-cycle frame strobe registers.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state       <= RECTANGLE;
            count       <= RELOAD;
            FrameStrobe <= 1'b0;
        end else begin
            state       <= state_next;
            count       <= count_next;
            FrameStrobe <= frame_start;
        end
    end

    assign ImageState = state;
    assign Paused     = paused;

endmodule
